apb_periph_bank: RTL and testbench
==================================

# apb_periph_bank

Zero-wait-state APB slave block directly downstream of the AHB-to-APB bridge. It consumes the bridge's `Pselx`/`Penable`/`Pwrite`/`Paddr`/`Pwdata` outputs and returns `Prdata`. It implements three independent register banks, one per `Pselx` bit. Each bank has `REGS_PER_SLAVE` 32-bit registers, and its last register is a read-only write counter. The bridge has no `Pready`/`Pslverr`, so every transfer completes in exactly one SETUP plus one ACCESS cycle.

## Interface
- `REGS_PER_SLAVE`, 8, registers per bank; power of two, range 2..64; index width `IW = log2(REGS_PER_SLAVE)`.
- `Hclk`  in  1  single clock, rising edge.
- `Hresetn`  in  1  asynchronous, active-low reset.
- `Pselx`  in  3  one-hot slave select; bit k selects bank k.
- `Penable`  in  1  APB enable (ACCESS phase).
- `Pwrite`  in  1  1 = write, 0 = read.
- `Paddr`  in  32  byte address; `Paddr[IW+1:2]` is the register index, other bits are ignored.
- `Pwdata`  in  32  write data.
- `Prdata`  out  32  registered read data.
- `Perr`  out  1  sticky protocol-error flag.

## Operation
- Phase FSM states: IDLE, SETUP, ACCESS. All transitions are evaluated at the `Hclk` rising edge.
  - IDLE → SETUP when `Pselx != 0` and `!Penable`.
  - SETUP → ACCESS when `Pselx != 0` and `Penable`.
  - ACCESS → SETUP when `Pselx != 0` and `!Penable` (back-to-back transfer).
  - ACCESS → IDLE when `Pselx == 0`.
  - Any other input combination: go to IDLE and flag a violation.
- Write commit happens on the ACCESS-cycle edge: state is SETUP, `Penable=1`, `Pwrite=1`, and exactly one `Pselx` bit is set. The commit writes `Pwdata` to `bank[k][idx]`.
- Register `REGS_PER_SLAVE-1` of each bank is WRCNT:
  - It is read-only; writes to it are dropped and are not counted.
  - It increments by 1 on every committed write to indices `0..REGS_PER_SLAVE-2` of its own bank.
  - It is 32 bits wide and wraps from `0xFFFF_FFFF` to 0.
- Read capture happens on the SETUP-cycle edge: `Pselx` one-hot, `!Penable`, `!Pwrite`. The edge loads `Prdata <= bank[k][idx]`, so data is stable for the whole ACCESS cycle.
- `Prdata` holds its value at all other times. On a read SETUP edge with multiple `Pselx` bits set, `Prdata <= 0`.
- A multi-bit `Pselx` never writes any bank.
- Reset values:
  - all bank registers = 0
  - WRCNT = 0
  - `Prdata = 0`
  - `Perr = 0`
  - FSM = IDLE
- Reset asserted mid-transfer aborts the transfer immediately. No partial write occurs; a write whose commit edge coincides with reset assertion is lost.

## Timing
- Write: the register value is visible on the edge ending the ACCESS cycle. A read SETUP placed in the next cycle returns the new value.
- Read: 1-cycle latency from the SETUP edge. `Prdata` is valid for the full ACCESS cycle, which is when the bridge samples it.
- WRCNT updates on the same edge as the counted write.
- Back-to-back transfers (ACCESS → SETUP) sustain one transfer every 2 cycles with no idle cycle required.
- There are no wait states and no combinational path from inputs to `Prdata`.

## Configuration
- `APB_PROTOCOL_CHECK_EN` defined: `Perr` is set on the edge following any of these violations and stays high until `Hresetn`:
  - `Penable` high in IDLE.
  - SETUP not followed by ACCESS.
  - `Pselx`, `Paddr` or `Pwrite` changing between SETUP and ACCESS.
  - More than one `Pselx` bit set.
- `APB_PROTOCOL_CHECK_EN` undefined: the checker logic is removed and `Perr` is tied to 0. The FSM, writes and reads are unchanged, including the multi-select suppression.

## Structure
- Shared package `apb_periph_pkg` holds:
  - the phase-state enum (IDLE/SETUP/ACCESS)
  - `NUM_SLAVES = 3`
  - `APB_DW = 32`
  - the WRCNT index function
- Sub-module `apb_reg_bank` holds one bank: the register array, the WRCNT counter, a write port and a read port. It is instantiated 3 times.
- The top level owns the FSM, the select decode, the `Prdata` register and the checker.

## Test plan
- Reset: after `Hresetn` is deasserted, read every register of banks 0..2 → all return `0x0000_0000`; `Perr=0`.
- Write `0xDEAD_BEEF` to bank 1 (`Pselx=3'b010`) at `Paddr=0x0000_0008` (index 2), then read it back → `Prdata=0xDEAD_BEEF` during ACCESS. Index 2 of banks 0 and 2 still reads 0. Bank 1 WRCNT (index 7) reads 1.
- Write `0x1234_5678` to index 7 of bank 0 → dropped. Bank 0 WRCNT reads 0 and `Perr=0`.
- Preload bank 2 WRCNT to `0xFFFF_FFFF` through 2^32−1 writes, or use a force in the bench. One further write → WRCNT reads `0x0000_0000`.
- Back-to-back sequence: write b0[0]=`0xA5`, then read b0[0], with no idle cycle between them → read returns `0xA5`.
- With `APB_PROTOCOL_CHECK_EN`:
  - `Pselx=3'b011` write → no bank changes and `Perr=1` on the next edge. `Perr` stays 1 through later legal transfers and clears only on reset.
  - Without the macro, the same stimulus gives `Perr=0` and no bank change.

Source files
------------

// File: rtl/apb_periph_pkg.sv
// apb_periph_pkg
// Shared definitions for the APB peripheral register bank:
//   apb_phase_e  - APB phase state (IDLE / SETUP / ACCESS)
//   NUM_SLAVES   - number of register banks (one per Pselx bit)
//   APB_DW       - APB data width
//   wrcnt_index  - index of the read-only write counter in a bank
package apb_periph_pkg;

    localparam int NUM_SLAVES = 3;
    localparam int APB_DW     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_phase_e;

    function automatic int unsigned wrcnt_index(input int unsigned regs);
        return regs - 1;
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// apb_reg_bank
// One register bank: REGS_PER_SLAVE-1 read/write registers plus a read-only
// write counter (WRCNT) at the last index.
// Ports:
//   Hclk, Hresetn  clock, asynchronous active-low reset
//   we             write strobe (already qualified as a legal commit)
//   widx, wdata    write index and data
//   ridx, rdata    combinational read port
module apb_reg_bank
    import apb_periph_pkg::*;
#(
    parameter int REGS_PER_SLAVE = 8,
    parameter int IW             = $clog2(REGS_PER_SLAVE)
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              we,
    input  logic [IW-1:0]     widx,
    input  logic [APB_DW-1:0] wdata,
    input  logic [IW-1:0]     ridx,
    output logic [APB_DW-1:0] rdata
);

    localparam logic [IW-1:0] WR_IDX = IW'(wrcnt_index(REGS_PER_SLAVE));

    logic [APB_DW-1:0] mem [REGS_PER_SLAVE-1];
    logic [APB_DW-1:0] wrcnt;

    // Writes aimed at WRCNT are silently dropped and not counted.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            for (int i = 0; i < REGS_PER_SLAVE - 1; i++) begin
                mem[i] <= '0;
            end
            wrcnt <= '0;
        end else if (we && (widx != WR_IDX)) begin
            mem[widx] <= wdata;
            wrcnt     <= wrcnt + APB_DW'(1);
        end
    end

    assign rdata = (ridx == WR_IDX) ? wrcnt : mem[ridx];

endmodule

// File: rtl/apb_periph_bank.sv
// apb_periph_bank
// Zero-wait-state APB slave with NUM_SLAVES independent register banks.
// Every transfer is one SETUP plus one ACCESS cycle; Prdata is registered
// on the SETUP edge so it is stable for the whole ACCESS cycle.
// Ports:
//   Hclk, Hresetn   clock, asynchronous active-low reset
//   Pselx           one-hot bank select
//   Penable         ACCESS-phase indicator
//   Pwrite          1 = write, 0 = read
//   Paddr           byte address, Paddr[IW+1:2] is the register index
//   Pwdata          write data
//   Prdata          registered read data
//   Perr            sticky protocol-error flag
// Build option: define APB_PROTOCOL_CHECK_EN to enable the protocol checker;
// otherwise Perr is tied low.
//
// state  | meaning
// IDLE   | no transfer in progress
// SETUP  | select presented, waiting for Penable
// ACCESS | transfer completing (write committed on the edge ending SETUP)
module apb_periph_bank
    import apb_periph_pkg::*;
#(
    parameter int REGS_PER_SLAVE = 8
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic [NUM_SLAVES-1:0] Pselx,
    input  logic                  Penable,
    input  logic                  Pwrite,
    input  logic [31:0]           Paddr,
    input  logic [APB_DW-1:0]     Pwdata,
    output logic [APB_DW-1:0]     Prdata,
    output logic                  Perr
);

    localparam int IW = $clog2(REGS_PER_SLAVE);

    apb_phase_e state, state_nxt;

    logic              sel_any;
    logic              sel_onehot;
    logic [IW-1:0]     idx;
    logic              commit;
    logic              rd_capture;
    logic [APB_DW-1:0] rd_mux;
    logic [APB_DW-1:0] bank_rdata [NUM_SLAVES];
    logic              unused_addr_bits;

    assign sel_any    = |Pselx;
    assign sel_onehot = sel_any && ((Pselx & (Pselx - NUM_SLAVES'(1))) == '0);
    assign idx        = Paddr[IW+1:2];
    assign unused_addr_bits = ^{Paddr[31:IW+2], Paddr[1:0]};

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    if (sel_any && !Penable) state_nxt = SETUP;
            SETUP:   if (sel_any &&  Penable) state_nxt = ACCESS;
            ACCESS:  if (sel_any && !Penable) state_nxt = SETUP;
            default: state_nxt = IDLE;
        endcase
    end

    // Multi-bit selects never commit, in every build.
    assign commit     = (state == SETUP) && Penable && Pwrite && sel_onehot;
    assign rd_capture = sel_any && !Penable && !Pwrite;

    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_bank
        apb_reg_bank #(
            .REGS_PER_SLAVE (REGS_PER_SLAVE),
            .IW             (IW)
        ) u_bank (
            .Hclk    (Hclk),
            .Hresetn (Hresetn),
            .we      (commit && Pselx[k]),
            .widx    (idx),
            .wdata   (Pwdata),
            .ridx    (idx),
            .rdata   (bank_rdata[k])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (Pselx[k]) rd_mux = bank_rdata[k];
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Prdata <= '0;
        end else if (rd_capture) begin
            Prdata <= sel_onehot ? rd_mux : '0;
        end
    end

`ifdef APB_PROTOCOL_CHECK_EN
    logic [NUM_SLAVES-1:0] setup_sel;
    logic [31:0]           setup_addr;
    logic                  setup_wr;
    logic                  violation;
    logic                  perr_q;

    // Snapshot the SETUP-phase controls so ACCESS can be checked against them.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            setup_sel  <= '0;
            setup_addr <= '0;
            setup_wr   <= 1'b0;
        end else if (state_nxt == SETUP) begin
            setup_sel  <= Pselx;
            setup_addr <= Paddr;
            setup_wr   <= Pwrite;
        end
    end

    always_comb begin
        violation = sel_any && !sel_onehot;
        case (state)
            IDLE:    if (Penable) violation = 1'b1;
            SETUP:   if (!(sel_any && Penable) || (Pselx != setup_sel) ||
                         (Paddr != setup_addr) || (Pwrite != setup_wr))
                         violation = 1'b1;
            ACCESS:  if (sel_any && Penable) violation = 1'b1;
            default: violation = 1'b1;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            perr_q <= 1'b0;
        end else if (violation) begin
            perr_q <= 1'b1;
        end
    end

    assign Perr = perr_q;
`else
    assign Perr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_periph_bank.sv
module tb_apb_periph_bank;

    localparam int NS   = 3;
    localparam int REGS = 8;
`ifdef APB_PROTOCOL_CHECK_EN
    localparam bit PERR_ON = 1'b1;
`else
    localparam bit PERR_ON = 1'b0;
`endif

    logic        Hclk    = 1'b0;
    logic        Hresetn = 1'b0;
    logic [2:0]  Pselx   = '0;
    logic        Penable = 1'b0;
    logic        Pwrite  = 1'b0;
    logic [31:0] Paddr   = '0;
    logic [31:0] Pwdata  = '0;
    logic [31:0] Prdata;
    logic        Perr;

    int checks   = 0;
    int failures = 0;

    // Transfer-level model: bank contents (last index = write counter),
    // the value Prdata must hold, and the sticky error flag.
    logic [31:0] mdl [NS][REGS];
    logic [31:0] exp_prdata = '0;
    logic        exp_perr   = 1'b0;

    apb_periph_bank #(.REGS_PER_SLAVE(REGS)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .Pselx   (Pselx),
        .Penable (Penable),
        .Pwrite  (Pwrite),
        .Paddr   (Paddr),
        .Pwdata  (Pwdata),
        .Prdata  (Prdata),
        .Perr    (Perr)
    );

    always #5 Hclk = ~Hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int sel_bank(input logic [2:0] sel);
        if ($countones(sel) != 1) return -1;
        for (int k = 0; k < NS; k++) if (sel[k]) return k;
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] sel, input logic [31:0] addr);
        int k;
        k = sel_bank(sel);
        if (k < 0) return 32'h0;
        return mdl[k][addr[4:2]];
    endfunction

    task automatic model_write(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] d);
        int k;
        int i;
        k = sel_bank(sel);
        i = int'(addr[4:2]);
        if (k >= 0 && i != REGS - 1) begin
            mdl[k][i]        = d;
            mdl[k][REGS - 1] = mdl[k][REGS - 1] + 32'd1;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NS; k++)
            for (int i = 0; i < REGS; i++) mdl[k][i] = '0;
        exp_prdata = '0;
        exp_perr   = 1'b0;
    endtask

    // Outputs are registered and hold between transfers, so they are
    // meaningful on every cycle.
    always @(negedge Hclk) begin
        check("prdata_cycle", Prdata, exp_prdata);
        check("perr_cycle", {31'd0, Perr}, {31'd0, exp_perr});
    end

    task automatic reset_dut();
        Hresetn = 1'b0;
        Pselx   = '0;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        model_clear();
        repeat (2) @(posedge Hclk);
        #1 Hresetn = 1'b1;
    endtask

    // One SETUP + ACCESS transfer. With chk set, Prdata is compared with the
    // hand-computed value in the middle of ACCESS. idle_after=0 leaves the
    // bus ready for a back-to-back SETUP.
    task automatic xfer(input bit wr, input logic [2:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit chk, input logic [31:0] req,
                        input string name, input bit idle_after);
        Pselx   = sel;
        Paddr   = addr;
        Pwrite  = wr;
        Pwdata  = wdata;
        Penable = 1'b0;
        @(posedge Hclk);
        if (!wr) exp_prdata = model_read(sel, addr);
        if ($countones(sel) > 1 && PERR_ON) exp_perr = 1'b1;
        #1 Penable = 1'b1;
        @(negedge Hclk);
        if (chk) check(name, Prdata, req);
        @(posedge Hclk);
        if (wr) model_write(sel, addr, wdata);
        #1;
        if (idle_after) begin
            Pselx   = '0;
            Penable = 1'b0;
            Pwrite  = 1'b0;
            @(posedge Hclk);
            #1;
        end
    endtask

    initial begin
        reset_dut();

        for (int k = 0; k < NS; k++)
            for (int i = 0; i < REGS; i++)
                xfer(1'b0, 3'(1 << k), 32'(i * 4), '0, 1'b1, 32'h0, "reset_read", 1'b1);
        @(negedge Hclk);
        check("perr_after_reset", {31'd0, Perr}, 32'd0);

        xfer(1'b1, 3'b010, 32'h8,  32'hDEAD_BEEF, 1'b0, '0, "", 1'b1);
        xfer(1'b0, 3'b010, 32'h8,  '0, 1'b1, 32'hDEAD_BEEF, "b1_idx2", 1'b1);
        xfer(1'b0, 3'b001, 32'h8,  '0, 1'b1, 32'h0, "b0_idx2", 1'b1);
        xfer(1'b0, 3'b100, 32'h8,  '0, 1'b1, 32'h0, "b2_idx2", 1'b1);
        xfer(1'b0, 3'b010, 32'h1C, '0, 1'b1, 32'h1, "b1_wrcnt", 1'b1);

        xfer(1'b1, 3'b001, 32'h1C, 32'h1234_5678, 1'b0, '0, "", 1'b1);
        xfer(1'b0, 3'b001, 32'h1C, '0, 1'b1, 32'h0, "b0_wrcnt_ro", 1'b1);
        check("perr_after_ro_write", {31'd0, Perr}, 32'd0);

        force dut.g_bank[2].u_bank.wrcnt = 32'hFFFF_FFFF;
        @(posedge Hclk);
        #1 release dut.g_bank[2].u_bank.wrcnt;
        mdl[2][REGS - 1] = 32'hFFFF_FFFF;
        xfer(1'b0, 3'b100, 32'h1C, '0, 1'b1, 32'hFFFF_FFFF, "b2_wrcnt_preload", 1'b1);
        xfer(1'b1, 3'b100, 32'h0,  32'h0000_0001, 1'b0, '0, "", 1'b1);
        xfer(1'b0, 3'b100, 32'h1C, '0, 1'b1, 32'h0, "b2_wrcnt_wrap", 1'b1);
        xfer(1'b0, 3'b100, 32'h0,  '0, 1'b1, 32'h1, "b2_idx0", 1'b1);

        xfer(1'b1, 3'b001, 32'h0,  32'h0000_00A5, 1'b0, '0, "", 1'b0);
        xfer(1'b0, 3'b001, 32'h0,  '0, 1'b1, 32'h0000_00A5, "b2b_read", 1'b0);
        xfer(1'b1, 3'b001, 32'hABCD_E0E7, 32'h600D_F00D, 1'b0, '0, "", 1'b0);
        xfer(1'b0, 3'b001, 32'h4,  '0, 1'b1, 32'h600D_F00D, "addr_ignored_bits", 1'b1);
        xfer(1'b0, 3'b001, 32'h1C, '0, 1'b1, 32'h2, "b0_wrcnt_two", 1'b1);

        xfer(1'b1, 3'b011, 32'hC,  32'h0000_0055, 1'b0, '0, "", 1'b1);
        @(negedge Hclk);
        check("perr_multi_sel", {31'd0, Perr}, {31'd0, PERR_ON});
        xfer(1'b0, 3'b001, 32'hC,  '0, 1'b1, 32'h0, "multi_b0_idx3", 1'b1);
        xfer(1'b0, 3'b010, 32'hC,  '0, 1'b1, 32'h0, "multi_b1_idx3", 1'b1);
        xfer(1'b0, 3'b010, 32'h1C, '0, 1'b1, 32'h1, "multi_b1_wrcnt", 1'b1);
        xfer(1'b0, 3'b010, 32'h8,  '0, 1'b1, 32'hDEAD_BEEF, "b1_idx2_again", 1'b1);
        xfer(1'b0, 3'b110, 32'h8,  '0, 1'b1, 32'h0, "multi_read_zero", 1'b1);
        xfer(1'b1, 3'b100, 32'h4,  32'h0000_0077, 1'b0, '0, "", 1'b1);
        check("perr_sticky", {31'd0, Perr}, {31'd0, PERR_ON});

        reset_dut();
        @(negedge Hclk);
        check("perr_cleared", {31'd0, Perr}, 32'd0);
        xfer(1'b0, 3'b010, 32'h8,  '0, 1'b1, 32'h0, "b1_idx2_after_reset", 1'b1);
        xfer(1'b0, 3'b100, 32'h1C, '0, 1'b1, 32'h0, "b2_wrcnt_after_reset", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
